// File: rtl/button_pkg.sv
// Shared constants and types for the Mode/Trip button input peripheral.
package button_pkg;

    localparam logic [1:0]  STATUS_ADDR = 2'd0;
    localparam logic [1:0]  LEVEL_ADDR  = 2'd1;
    localparam logic [1:0]  ID_ADDR     = 2'd2;
    localparam logic [31:0] ID_VALUE    = 32'h0000_B077;

    localparam int ST_MODE_SHORT = 0;
    localparam int ST_TRIP_SHORT = 1;
    localparam int ST_MODE_LONG  = 2;
    localparam int ST_TRIP_LONG  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// One push-button path: 2-flop synchroniser, debouncer and short/long press classifier.
// state | meaning
// IDLE  | button released (debounced)
// HELD  | pressed, hold time still below the long-press threshold
// LONG  | long press already reported, waiting for release
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 2000000
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic btn_n,
    output logic level,
    output logic short_evt,
    output logic long_evt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    btn_state_t    state_q, state_d;
    logic          pressed;

    // Events decode off the next debounced level so status latches on the same edge as the level change.
    always_comb begin
        sync_d    = {sync_q[0], btn_n};
        pressed   = ~sync_q[1];
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        state_d   = state_q;
        hold_d    = hold_q;
        short_evt = 1'b0;
        long_evt  = 1'b0;

        if (pressed == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            level_d   = pressed;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end

        case (state_q)
            IDLE: begin
                if (level_d && !level_q) begin
                    state_d = HELD;
                    hold_d  = '0;
                end
            end
            HELD: begin
                if (!level_d) begin
                    state_d   = IDLE;
                    short_evt = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d  = LONG;
                    long_evt = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            LONG: begin
                if (!level_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q    <= 2'b11;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
            hold_q    <= '0;
            state_q   <= IDLE;
        end else begin
            sync_q    <= sync_d;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/button_manager.sv
// AHB-Lite read-only slave exposing sticky press events and debounced levels
// for the Mode and Trip buttons.
module button_manager
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 2000000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        nMode,
    input  logic        nTrip
);

    logic       read_q, read_d;
    logic [1:0] addr_q, addr_d;
    logic [3:0] status_q, status_d;
    logic [3:0] status_set;
    logic       rd_clear;
    logic       mode_level, mode_short, mode_long;
    logic       trip_level, trip_short, trip_long;
    logic       unused_bits;

    assign unused_bits = ^{HWDATA, HSIZE, HADDR[31:4], HADDR[1:0]};

    button_channel #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_mode (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .btn_n    (nMode),
        .level    (mode_level),
        .short_evt(mode_short),
        .long_evt (mode_long)
    );

    button_channel #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_trip (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .btn_n    (nTrip),
        .level    (trip_level),
        .short_evt(trip_short),
        .long_evt (trip_long)
    );

    // A new event on the clearing edge is OR'd in after the clear, so it is never lost.
    always_comb begin
        read_d = 1'b0;
        addr_d = 2'b00;
        if (HSEL && HREADY && (HTRANS != 2'b00)) begin
            read_d = !HWRITE;
            addr_d = HADDR[3:2];
        end

        status_set                = '0;
        status_set[ST_MODE_SHORT] = mode_short;
        status_set[ST_TRIP_SHORT] = trip_short;
        status_set[ST_MODE_LONG]  = mode_long;
        status_set[ST_TRIP_LONG]  = trip_long;

        rd_clear = read_q && HREADY && (addr_q == STATUS_ADDR);
        status_d = (rd_clear ? 4'b0000 : status_q) | status_set;

        HRDATA = 32'h0;
        if (read_q) begin
            case (addr_q)
                STATUS_ADDR: HRDATA = {28'h0, status_q};
                LEVEL_ADDR:  HRDATA = {30'h0, trip_level, mode_level};
                ID_ADDR:     HRDATA = ID_VALUE;
                default:     HRDATA = 32'h0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            read_q   <= 1'b0;
            addr_q   <= 2'b00;
            status_q <= 4'b0000;
        end else begin
            read_q   <= read_d;
            addr_q   <= addr_d;
            status_q <= status_d;
        end
    end

    assign HREADYOUT = 1'b1;

endmodule

// File: tb/tb_button_manager.sv
// Bench for button_manager: directed press scenarios plus randomized buttons and bus traffic,
// checked every cycle against an event-level reference model.
module tb_button_manager;

    localparam int DEB = 4;
    localparam int LP  = 20;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HREADY, HSEL, HREADYOUT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        nMode, nTrip;

    button_manager #(.DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LP)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .nMode(nMode), .nTrip(nTrip)
    );

    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw button seen two edges late; the level follows once the
    // sample has disagreed for DEB consecutive edges; press timing from timestamps.
    bit         d1[2], d2[2], lvl[2], long_done[2];
    int         run[2], t_press[2];
    int         cyc;
    logic [3:0] m_status;
    bit         m_read;
    logic [1:0] m_addr;

    task automatic m_reset();
        for (int ch = 0; ch < 2; ch++) begin
            d1[ch] = 1'b1; d2[ch] = 1'b1; lvl[ch] = 1'b0;
            long_done[ch] = 1'b0; run[ch] = 0; t_press[ch] = 0;
        end
        m_status = 4'h0;
        m_read   = 1'b0;
        m_addr   = 2'b00;
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_reset();
        end else begin
            logic [3:0] ev;
            bit seen, raw, released, clr;
            cyc++;
            ev  = 4'h0;
            clr = m_read && HREADY && (m_addr == 2'd0);
            for (int ch = 0; ch < 2; ch++) begin
                raw      = (ch == 0) ? nMode : nTrip;
                seen     = !d2[ch];
                d2[ch]   = d1[ch];
                d1[ch]   = raw;
                released = 1'b0;
                if (seen != lvl[ch]) begin
                    run[ch]++;
                    if (run[ch] == DEB) begin
                        lvl[ch] = seen;
                        run[ch] = 0;
                        if (seen) begin
                            t_press[ch]   = cyc;
                            long_done[ch] = 1'b0;
                        end else begin
                            released = 1'b1;
                            if (!long_done[ch]) ev[ch] = 1'b1;
                        end
                    end
                end else begin
                    run[ch] = 0;
                end
                if (!released && lvl[ch] && !long_done[ch] && (cyc - t_press[ch] == LP)) begin
                    ev[ch + 2]    = 1'b1;
                    long_done[ch] = 1'b1;
                end
            end
            m_status = (clr ? 4'h0 : m_status) | ev;
            m_read   = HSEL && HREADY && (HTRANS != 2'b00) && !HWRITE;
            m_addr   = (HSEL && HREADY && (HTRANS != 2'b00)) ? HADDR[3:2] : 2'b00;
        end
    end

    function automatic logic [31:0] exp_rdata();
        case (m_addr)
            2'd0:    return {28'h0, m_status};
            2'd1:    return {30'h0, lvl[1], lvl[0]};
            2'd2:    return 32'h0000_B077;
            default: return 32'h0;
        endcase
    endfunction

    bit chk_en = 1'b0;
    always @(negedge HCLK) begin
        if (chk_en) begin
            check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
            if (m_read) check("hrdata_model", HRDATA, exp_rdata());
        end
    end

    // Called at a negedge; returns at the negedge inside the data phase.
    task automatic bus_read(input logic [1:0] idx, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HREADY = 1'b1;
        HADDR = {28'h0, idx, 2'b00};
        @(negedge HCLK);
        data  = HRDATA;
        HSEL  = 1'b0; HTRANS = 2'b00; HADDR = 32'h0;
    endtask

    task automatic read_expect(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(idx, d);
        check(tag, d, exp);
    endtask

    int rem[2];

    function automatic int pick_len();
        case ($urandom_range(0, 2))
            0:       return $urandom_range(1, 3);
            1:       return $urandom_range(5, 18);
            default: return $urandom_range(24, 45);
        endcase
    endfunction

    initial begin
        m_reset();
        cyc = 0;
        HRESETn = 1'b0;
        HADDR = 32'h0; HWDATA = 32'h0; HWRITE = 1'b0; HREADY = 1'b1;
        HSEL = 1'b0; HSIZE = 3'b010; HTRANS = 2'b00;
        nMode = 1'b1; nTrip = 1'b1;
        repeat (3) @(negedge HCLK);
        check("reset_hrdata", HRDATA, 32'h0);
        check("reset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        HRESETn = 1'b1;
        chk_en  = 1'b1;
        @(negedge HCLK);

        // 1: identity and clean status
        read_expect("id", 2'd2, 32'h0000_B077);
        read_expect("status_after_reset", 2'd0, 32'h0);

        // 2: mode short press
        nMode = 1'b0;
        repeat (8) @(negedge HCLK);
        read_expect("mode_level_held", 2'd1, 32'h1);
        nMode = 1'b1;
        repeat (10) @(negedge HCLK);
        read_expect("mode_short", 2'd0, 32'h1);
        read_expect("mode_short_cleared", 2'd0, 32'h0);

        // 3: trip long press
        nTrip = 1'b0;
        repeat (40) @(negedge HCLK);
        nTrip = 1'b1;
        repeat (10) @(negedge HCLK);
        read_expect("trip_long", 2'd0, 32'h8);
        read_expect("trip_long_cleared", 2'd0, 32'h0);

        // 4: glitches below the debounce window
        for (int i = 0; i < 3; i++) begin
            nMode = 1'b0;
            repeat (2) @(negedge HCLK);
            nMode = 1'b1;
            repeat (2) @(negedge HCLK);
        end
        read_expect("glitch_level", 2'd1, 32'h0);
        read_expect("glitch_status", 2'd0, 32'h0);

        // 5: trip release lands on the read-clear edge
        nTrip = 1'b0;
        repeat (10) @(negedge HCLK);
        nTrip = 1'b1;
        repeat (4) @(negedge HCLK);
        read_expect("collision_first", 2'd0, 32'h0);
        read_expect("collision_second", 2'd0, 32'h2);

        // 6: reset while mode is held
        nMode = 1'b0;
        repeat (12) @(negedge HCLK);
        read_expect("pre_reset_level", 2'd1, 32'h1);
        HRESETn = 1'b0;
        #1;
        check("midreset_hrdata", HRDATA, 32'h0);
        check("midreset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);
        read_expect("post_reset_level_early", 2'd1, 32'h0);
        read_expect("post_reset_level_on_time", 2'd1, 32'h1);
        nMode = 1'b1;
        repeat (10) @(negedge HCLK);
        read_expect("post_reset_short", 2'd0, 32'h1);

        // Randomized buttons and bus traffic, checked cycle by cycle by the model
        rem[0] = pick_len();
        rem[1] = pick_len();
        for (int c = 0; c < 4000; c++) begin
            HSEL   = ($urandom_range(0, 3) != 0);
            HTRANS = 2'($urandom_range(0, 3));
            HWRITE = ($urandom_range(0, 3) == 0);
            HADDR  = $urandom;
            HWDATA = $urandom;
            HSIZE  = 3'($urandom_range(0, 7));
            HREADY = ($urandom_range(0, 9) != 0);
            for (int ch = 0; ch < 2; ch++) begin
                if (rem[ch] == 0) begin
                    if (ch == 0) nMode = ~nMode;
                    else         nTrip = ~nTrip;
                    rem[ch] = pick_len();
                end
                rem[ch]--;
            end
            @(negedge HCLK);
        end

        HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
        nMode = 1'b1; nTrip = 1'b1;
        repeat (30) @(negedge HCLK);
        read_expect("final_level", 2'd1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/button_manager.md
# button_manager

AHB-Lite read-side peripheral for the cycle computer: it samples the active-low Mode and Trip push-buttons, synchronises and debounces them, and classifies each press as short or long. It latches the resulting events in sticky status bits for firmware to poll. It sits on the same AHB-Lite slave bus as the display peripheral and provides the input path that complements the write-only display.

## Interface
- DEBOUNCE_CYCLES, default 50000: consecutive stable HCLK cycles needed before the debounced level changes.
- LONG_PRESS_CYCLES, default 2000000: HCLK cycles of continuous debounced hold that make a press long.
- HCLK  input  1  system clock; all state updates on its rising edge.
- HRESETn  input  1  reset, asynchronous, active-low; clock is HCLK.
- HADDR  input  32  only HADDR[3:2] decoded.
- HWDATA  input  32  ignored; block is read-only.
- HWRITE  input  1  write transfers complete with no effect.
- HREADY  input  1  bus ready.
- HSEL  input  1  slave select.
- HSIZE  input  3  ignored; every access is treated as 32-bit.
- HTRANS  input  2  IDLE (2'b00) is ignored.
- HRDATA  output  32  read data during the data phase.
- HREADYOUT  output  1  tied to 1; no wait states.
- nMode  input  1  Mode button, asynchronous, low = pressed.
- nTrip  input  1  Trip button, asynchronous, low = pressed.

## Operation
- **Memory map.**
  - Offset 0x0 STATUS: bit0 = mode short, bit1 = trip short, bit2 = mode long, bit3 = trip long. Sticky; cleared by reading.
  - Offset 0x4 LEVEL: bit0 = mode held, bit1 = trip held. Debounced level, not sticky.
  - Offset 0x8 ID: constant 32'h0000_B077.
  - Offset 0xC: reads 0.
  - Unused bits read 0.
- **Address phase.** On HSEL && HREADY && HTRANS != IDLE, register Read = !HWRITE and the 2-bit address. Otherwise register Read = 0 and address = 0.
- **Data phase.** HRDATA is combinational from the registered address and the current registers. It is only meaningful when Read = 1.
- **Read-clear.** A data-phase read of STATUS clears all four status bits at the clock edge that ends that data phase.
- **Set/clear collision.** If an event sets a status bit on the same edge as a read-clear, the set wins. That bit reads 1 on the next access; no event is lost.
- **Per-channel pipeline.** Each channel is a 2-flop synchroniser followed by a debouncer.
  - The debouncer's counter resets whenever the synchronised sample equals the debounced level.
  - It increments while the two differ.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter resets.
- **Per-channel FSM, states IDLE, HELD, LONG.**
  - IDLE -> HELD on debounced press; the hold counter clears.
  - In HELD the hold counter increments, saturating.
  - HELD -> IDLE on debounced release: pulse short_evt for 1 cycle.
  - HELD -> LONG when the hold counter reaches LONG_PRESS_CYCLES-1: pulse long_evt for 1 cycle.
  - LONG -> IDLE on debounced release, with no event.
- **Arithmetic.** Counter widths are $clog2(param+1). Counters never wrap.
- **Both buttons.** Simultaneous presses on both buttons are independent; both channels can raise events on the same edge.

## Timing
- **Reset values:**
  - HRDATA = 0 and HREADYOUT = 1.
  - All status bits, levels, counters and registered address/Read are 0.
  - Synchroniser flops reset to 1 (released), and every FSM resets to IDLE.
- **Press to LEVEL:** a clean edge on nMode/nTrip appears in LEVEL 2 (sync) + DEBOUNCE_CYCLES cycles later.
- **Release to short status:** a short press sets its STATUS bit on the same edge that the debounced level returns to 0.
- **Long status:** set LONG_PRESS_CYCLES cycles after the debounced press edge.
- **Glitches:** a glitch shorter than DEBOUNCE_CYCLES produces no level change and no event.
- **Reset mid-press:** an FSM reset while a button is held returns to IDLE. The button stays held through reset, so after reset it debounces as a new press.
- **Back-to-back reads:** two consecutive STATUS reads return the value, then 0, assuming no new event occurs between them.

## Structure
- **Package button_pkg:**
  - Address offset constants: STATUS_ADDR=0, LEVEL_ADDR=1, ID_ADDR=2.
  - ID value constant.
  - Enum btn_state_t {IDLE, HELD, LONG}.
  - Status bit index constants.
- **Sub-module button_channel:** synchroniser, debouncer and FSM, with parameters DEBOUNCE_CYCLES and LONG_PRESS_CYCLES. Outputs are level, short_evt and long_evt. It is instantiated twice, for Mode and Trip.
- **Top level:** AHB address register, sticky status, read mux and read-clear.

## Test plan
Simulate with DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=20.
1. Reset then read ID at 0x8 -> HRDATA=32'h0000_B077; STATUS reads 0; HREADYOUT=1 throughout.
2. nMode low for 10 cycles then high; read STATUS -> 32'h1; read again -> 0. LEVEL reads 1 during the hold.
3. nTrip low for 40 cycles -> STATUS=32'h8 once held past 20 cycles; no short bit after release.
4. nMode pulses low for 2 cycles, 3 times, 2 cycles apart -> LEVEL stays 0 and STATUS stays 0.
5. Trip short-press release timed to the same edge as a STATUS read-clear -> that read returns 0 or prior bits; the next read returns bit1 = 1.
6. Assert HRESETn low mid-hold with nMode held -> all outputs return to reset values; after release, a new press is detected after 2+4 cycles.
